wish_burst_slave: RTL and testbench

WISH_BURST_SLAVE -- requirements
Module: wish_burst_slave

---
 rtl/wish_burst_slave_if.sv | 35 +++
 rtl/wish_burst_slave.sv | 138 +++++++++++++
 tb/tb_wish_burst_slave.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/wish_burst_slave_if.sv
// Wishbone burst slave bus bundle: master handshake, memory-side strobes and latched access fields.
interface wish_burst_slave_if #(
  parameter int unsigned ADDRESS_LENGTH = 32,
  parameter int unsigned DATA_LENGTH    = 32
);
  localparam int unsigned SEL_WIDTH = DATA_LENGTH / 8;

  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [SEL_WIDTH-1:0]      sel;
  logic [2:0]                cti;
  logic [ADDRESS_LENGTH-1:0] ADR_I;
  logic [DATA_LENGTH-1:0]    DAT_I;
  logic [DATA_LENGTH-1:0]    DAT_mem_to_reg;
  logic                      ack;
  logic                      err;
  logic [DATA_LENGTH-1:0]    DAT_O;
  logic [ADDRESS_LENGTH-1:0] ADR_STR;
  logic [DATA_LENGTH-1:0]    DAT_STR;
  logic [SEL_WIDTH-1:0]      SEL_STR;
  logic                      read_en;
  logic                      write_en;
  logic                      busy;

  modport slave (
    input  cyc, stb, we, sel, cti, ADR_I, DAT_I, DAT_mem_to_reg,
    output ack, err, DAT_O, ADR_STR, DAT_STR, SEL_STR, read_en, write_en, busy
  );

  modport master (
    output cyc, stb, we, sel, cti, ADR_I, DAT_I, DAT_mem_to_reg,
    input  ack, err, DAT_O, ADR_STR, DAT_STR, SEL_STR, read_en, write_en, busy
  );
endinterface

// File: rtl/wish_burst_slave.sv
// Wishbone slave with incrementing-burst support that fronts a simple strobed memory port,
// decoding a single address window and inserting a fixed number of wait states.
module wish_burst_slave #(
  parameter int unsigned               ADDRESS_LENGTH = 32,
  parameter int unsigned               DATA_LENGTH    = 32,
  parameter logic [ADDRESS_LENGTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned               ADDR_SPAN      = 4096,
  parameter int unsigned               WAIT_STATES    = 0
) (
  input logic                clk,
  input logic                reset,
  wish_burst_slave_if.slave  bus
);
  localparam int unsigned SEL_WIDTH = DATA_LENGTH / 8;
  localparam logic [ADDRESS_LENGTH:0] ADDR_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDRESS_LENGTH:0] ADDR_HI = ADDR_LO + (ADDRESS_LENGTH+1)'(ADDR_SPAN);

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, ERR} state_e;

  state_e                    state_q, state_d;
  logic [ADDRESS_LENGTH-1:0] adr_q, adr_d;
  logic [DATA_LENGTH-1:0]    dat_q, dat_d;
  logic [SEL_WIDTH-1:0]      sel_q, sel_d;
  logic                      we_q, we_d;
  logic [3:0]                wcnt_q, wcnt_d;
  logic [DATA_LENGTH-1:0]    rdat_q, rdat_d;
  logic                      load_rd;
  logic [ADDRESS_LENGTH-1:0] burst_adr;

  // Extra top bit keeps the window end from wrapping when BASE_ADDR+ADDR_SPAN overflows.
  function automatic logic addr_bad(input logic [ADDRESS_LENGTH-1:0] a);
    logic [ADDRESS_LENGTH:0] ax;
    ax = {1'b0, a};
    return (ax < ADDR_LO) || (ax >= ADDR_HI) ||
           ((ax % (ADDRESS_LENGTH+1)'(SEL_WIDTH)) != '0);
  endfunction

  function automatic logic [DATA_LENGTH-1:0] mask_bytes(input logic [DATA_LENGTH-1:0] d,
                                                        input logic [SEL_WIDTH-1:0] s);
    logic [DATA_LENGTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    end
    return r;
  endfunction

  assign burst_adr = adr_q + ADDRESS_LENGTH'(SEL_WIDTH);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wcnt_d  = wcnt_q;
    rdat_d  = rdat_q;
    load_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cyc && bus.stb) begin
          adr_d   = bus.ADR_I;
          dat_d   = bus.DAT_I;
          sel_d   = bus.sel;
          we_d    = bus.we;
          state_d = addr_bad(bus.ADR_I) ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.cyc) begin
          state_d = IDLE;
        end else if (WAIT_STATES > 0) begin
          state_d = WAIT;
          wcnt_d  = 4'(WAIT_STATES - 1);
        end else begin
          state_d = RESP;
          load_rd = 1'b1;
        end
      end
      WAIT: begin
        if (!bus.cyc) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == '0) begin
          state_d = RESP;
          load_rd = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      RESP: begin
        // Only an incrementing burst continues; every other cti value ends like a classic cycle.
        if (bus.cyc && bus.stb && (bus.cti == 3'b010)) begin
          adr_d   = burst_adr;
          dat_d   = bus.DAT_I;
          sel_d   = bus.sel;
          we_d    = bus.we;
          state_d = addr_bad(burst_adr) ? ERR : ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load_rd && !we_q) rdat_d = mask_bytes(bus.DAT_mem_to_reg, sel_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wcnt_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wcnt_q  <= wcnt_d;
      rdat_q  <= rdat_d;
    end
  end

  assign bus.read_en  = (state_q == ACCESS) && !we_q;
  assign bus.write_en = (state_q == ACCESS) && we_q;
  assign bus.ack      = (state_q == RESP) && bus.cyc;
  assign bus.err      = (state_q == ERR) && bus.cyc;
  assign bus.busy     = (state_q != IDLE);
  assign bus.DAT_O    = rdat_q;
  assign bus.ADR_STR  = adr_q;
  assign bus.DAT_STR  = dat_q;
  assign bus.SEL_STR  = sel_q;
endmodule

// File: tb/tb_wish_burst_slave.sv
// Directed bench for wish_burst_slave: three instances cover zero, two and three wait states.
module tb_wish_burst_slave;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  wish_burst_slave_if #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32)) b0 ();
  wish_burst_slave_if #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32)) b2 ();
  wish_burst_slave_if #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32)) b3 ();

  wish_burst_slave #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32), .BASE_ADDR(32'h0),
                     .ADDR_SPAN(4096), .WAIT_STATES(0))
    u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  wish_burst_slave #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32), .BASE_ADDR(32'h0),
                     .ADDR_SPAN(4096), .WAIT_STATES(2))
    u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  wish_burst_slave #(.ADDRESS_LENGTH(32), .DATA_LENGTH(32), .BASE_ADDR(32'h0),
                     .ADDR_SPAN(4096), .WAIT_STATES(3))
    u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    b0.cyc = 0; b0.stb = 0; b0.we = 0; b0.sel = '0; b0.cti = '0;
    b0.ADR_I = '0; b0.DAT_I = '0; b0.DAT_mem_to_reg = '0;
    b2.cyc = 0; b2.stb = 0; b2.we = 0; b2.sel = '0; b2.cti = '0;
    b2.ADR_I = '0; b2.DAT_I = '0; b2.DAT_mem_to_reg = '0;
    b3.cyc = 0; b3.stb = 0; b3.we = 0; b3.sel = '0; b3.cti = '0;
    b3.ADR_I = '0; b3.DAT_I = '0; b3.DAT_mem_to_reg = '0;
    #3 reset = 1'b0;
    #4;
    chk("rst_busy", b0.busy, 0);
    chk("rst_ack", b0.ack, 0);
    chk("rst_err", b0.err, 0);
    chk("rst_wen", b0.write_en, 0);
    chk("rst_dato", b0.DAT_O, 32'h0);
    chk("rst_adrstr", b0.ADR_STR, 32'h0);
    @(negedge clk) reset = 1'b1;
    tick();

    // single write, zero wait states
    b0.cyc = 1; b0.stb = 1; b0.we = 1; b0.ADR_I = 32'h10; b0.DAT_I = 32'hDEADBEEF;
    b0.sel = 4'hF; b0.cti = 3'b000;
    tick();
    chk("w_wen_c1", b0.write_en, 1);
    chk("w_ren_c1", b0.read_en, 0);
    chk("w_adrstr", b0.ADR_STR, 32'h10);
    chk("w_datstr", b0.DAT_STR, 32'hDEADBEEF);
    chk("w_selstr", b0.SEL_STR, 32'hF);
    chk("w_ack_c1", b0.ack, 0);
    tick();
    chk("w_ack_c2", b0.ack, 1);
    chk("w_wen_c2", b0.write_en, 0);
    chk("w_err_c2", b0.err, 0);
    b0.cyc = 0; b0.stb = 0;
    tick();
    chk("w_busy_end", b0.busy, 0);

    // read with two wait states and partial byte selects
    b2.DAT_mem_to_reg = 32'h12345678;
    b2.cyc = 1; b2.stb = 1; b2.we = 0; b2.ADR_I = 32'h20; b2.sel = 4'b0011; b2.cti = 3'b000;
    tick();
    chk("r2_ren_c1", b2.read_en, 1);
    tick();
    chk("r2_ren_c2", b2.read_en, 0);
    chk("r2_ack_c2", b2.ack, 0);
    tick();
    chk("r2_ack_c3", b2.ack, 0);
    chk("r2_busy_c3", b2.busy, 1);
    tick();
    chk("r2_ack_c4", b2.ack, 1);
    chk("r2_dato", b2.DAT_O, 32'h00005678);
    b2.cyc = 0; b2.stb = 0;
    tick();
    chk("r2_busy_end", b2.busy, 0);
    chk("r2_dato_hold", b2.DAT_O, 32'h00005678);

    // out-of-window read
    b0.cyc = 1; b0.stb = 1; b0.we = 0; b0.ADR_I = 32'h1000; b0.sel = 4'hF; b0.cti = 3'b000;
    tick();
    chk("oor_err", b0.err, 1);
    chk("oor_ack", b0.ack, 0);
    chk("oor_ren", b0.read_en, 0);
    b0.cyc = 0; b0.stb = 0;
    tick();
    chk("oor_err_end", b0.err, 0);
    chk("oor_busy_end", b0.busy, 0);
    chk("oor_ren_end", b0.read_en, 0);

    // misaligned read
    b0.cyc = 1; b0.stb = 1; b0.ADR_I = 32'h2;
    tick();
    chk("mis_err", b0.err, 1);
    chk("mis_ack", b0.ack, 0);
    chk("mis_ren", b0.read_en, 0);
    b0.cyc = 0; b0.stb = 0;
    tick();
    chk("mis_err_end", b0.err, 0);
    chk("mis_busy_end", b0.busy, 0);

    // write burst running off the end of the window
    b0.cyc = 1; b0.stb = 1; b0.we = 1; b0.ADR_I = 32'hFF4; b0.DAT_I = 32'hA0;
    b0.sel = 4'hF; b0.cti = 3'b010;
    tick();
    chk("bw_adr0", b0.ADR_STR, 32'hFF4);
    chk("bw_wen0", b0.write_en, 1);
    tick();
    chk("bw_ack0", b0.ack, 1);
    b0.DAT_I = 32'hA1;
    tick();
    chk("bw_adr1", b0.ADR_STR, 32'hFF8);
    chk("bw_dat1", b0.DAT_STR, 32'hA1);
    chk("bw_wen1", b0.write_en, 1);
    tick();
    chk("bw_ack1", b0.ack, 1);
    b0.DAT_I = 32'hA2;
    tick();
    chk("bw_adr2", b0.ADR_STR, 32'hFFC);
    chk("bw_dat2", b0.DAT_STR, 32'hA2);
    tick();
    chk("bw_ack2", b0.ack, 1);
    b0.DAT_I = 32'hA3;
    tick();
    chk("bw_err3", b0.err, 1);
    chk("bw_ack3", b0.ack, 0);
    chk("bw_wen3", b0.write_en, 0);
    chk("bw_adr3", b0.ADR_STR, 32'h1000);
    b0.cti = 3'b111;
    b0.cyc = 0; b0.stb = 0;
    tick();
    chk("bw_busy_end", b0.busy, 0);

    // read burst closed by an end-of-burst beat while the request is still held
    b0.DAT_mem_to_reg = 32'hCAFEF00D;
    b0.cyc = 1; b0.stb = 1; b0.we = 0; b0.ADR_I = 32'h40; b0.sel = 4'b1100; b0.cti = 3'b010;
    tick();
    chk("br_ren0", b0.read_en, 1);
    tick();
    chk("br_ack0", b0.ack, 1);
    chk("br_dato0", b0.DAT_O, 32'hCAFE0000);
    b0.sel = 4'b0001; b0.DAT_mem_to_reg = 32'h11223344;
    tick();
    chk("br_adr1", b0.ADR_STR, 32'h44);
    chk("br_sel1", b0.SEL_STR, 32'h1);
    chk("br_ren1", b0.read_en, 1);
    chk("br_dato_hold", b0.DAT_O, 32'hCAFE0000);
    b0.cti = 3'b111;
    tick();
    chk("br_ack1", b0.ack, 1);
    chk("br_dato1", b0.DAT_O, 32'h00000044);
    tick();
    chk("br_idle", b0.busy, 0);
    chk("br_ren_idle", b0.read_en, 0);
    b0.cyc = 0; b0.stb = 0;

    // abort by dropping cyc in the second wait cycle
    b3.cyc = 1; b3.stb = 1; b3.we = 1; b3.ADR_I = 32'h30; b3.DAT_I = 32'h55;
    b3.sel = 4'hF; b3.cti = 3'b000;
    tick();
    chk("ab_wen", b3.write_en, 1);
    tick();
    chk("ab_busy_w1", b3.busy, 1);
    chk("ab_ack_w1", b3.ack, 0);
    tick();
    b3.cyc = 0; b3.stb = 0;
    tick();
    chk("ab_busy_end", b3.busy, 0);
    chk("ab_ack_end", b3.ack, 0);
    chk("ab_wen_end", b3.write_en, 0);

    // asynchronous reset in the middle of a wait state
    b3.DAT_mem_to_reg = 32'hAABBCCDD;
    b3.cyc = 1; b3.stb = 1; b3.we = 0; b3.ADR_I = 32'h34; b3.sel = 4'hF;
    tick();
    chk("ar_ren", b3.read_en, 1);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", b3.busy, 0);
    chk("ar_ren0", b3.read_en, 0);
    chk("ar_ack", b3.ack, 0);
    chk("ar_err", b3.err, 0);
    chk("ar_adrstr", b3.ADR_STR, 32'h0);
    chk("ar_datstr", b3.DAT_STR, 32'h0);
    chk("ar_selstr", b3.SEL_STR, 32'h0);
    chk("ar_dato", b3.DAT_O, 32'h0);
    @(negedge clk) reset = 1'b1;
    tick();
    chk("pr_ren_c1", b3.read_en, 1);
    chk("pr_adrstr", b3.ADR_STR, 32'h34);
    tick();
    tick();
    tick();
    chk("pr_ack_c4", b3.ack, 0);
    tick();
    chk("pr_ack_c5", b3.ack, 1);
    chk("pr_dato", b3.DAT_O, 32'hAABBCCDD);
    b3.cyc = 0; b3.stb = 0;
    tick();
    chk("pr_busy_end", b3.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
